// File: rtl/money_sequencer.sv
// money_sequencer: control stage for the per-digit BCD accumulators of the money path.
// Coins and purchases become digit-serial add/subtract sequences (LSD first). A shadow copy
// of the credit supplies each digit's carry/borrow and drives the overflow/underflow refusals.
module money_sequencer #(
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  coin_valid,
  input  logic [1:0]            coin_code,
  input  logic                  buy_req,
  input  logic [4*DIGITS-1:0]   price_bcd,
  output logic                  buy_ack,
  output logic                  buy_reject,
  output logic                  coin_reject,
  output logic [3:0]            dig_num,
  output logic                  dig_cin,
  output logic                  dig_mode,
  output logic [DIGITS-1:0]     dig_en,
  output logic [4*DIGITS-1:0]   credit_bcd,
  output logic                  busy,
  output logic                  done
);

  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DW-1:0] LAST_DIG = DW'(DIGITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CHECK, S_SETUP, S_STROBE, S_DONE
  } state_t;

  state_t            r_state, w_state_next;
  logic [DW-1:0]     r_dig, w_dig_next;
  logic [1:0]        r_coin_code, w_coin_code_next;
  logic              r_pend_valid, w_pend_valid_next;
  logic [1:0]        r_pend_code, w_pend_code_next;
  logic [3:0]        r_oper [DIGITS];
  logic [3:0]        w_oper_next [DIGITS];
  logic [3:0]        r_cred [DIGITS];
  logic [3:0]        w_cred_next [DIGITS];

  logic              r_buy_ack, w_buy_ack_next;
  logic              r_buy_reject, w_buy_reject_next;
  logic              r_coin_reject, w_coin_reject_next;
  logic [3:0]        r_dig_num, w_dig_num_next;
  logic              r_dig_cin, w_dig_cin_next;
  logic              r_dig_mode, w_dig_mode_next;
  logic [DIGITS-1:0] r_dig_en, w_dig_en_next;
  logic              r_busy, r_done, w_done_next;

  // Coin value as two BCD digits, per-digit views of coin, price and credit
  logic [7:0]          w_coin_bcd;
  logic [3:0]          w_coin_dig [DIGITS];
  logic [3:0]          w_price_dig [DIGITS];
  logic [4*DIGITS-1:0] w_credit_bcd;
  logic [4*DIGITS-1:0] w_limit;
  logic                w_coin_wide;
  logic                w_overflow;
  logic                w_short;

  always_comb begin
    case (r_coin_code)
      2'b00:   w_coin_bcd = 8'h01;
      2'b01:   w_coin_bcd = 8'h02;
      2'b10:   w_coin_bcd = 8'h05;
      default: w_coin_bcd = 8'h10;
    endcase
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    if (gi == 0) begin : g_lo
      assign w_coin_dig[gi] = w_coin_bcd[3:0];
    end else if (gi == 1) begin : g_hi
      assign w_coin_dig[gi] = w_coin_bcd[7:4];
    end else begin : g_zero
      assign w_coin_dig[gi] = 4'd0;
    end
    assign w_price_dig[gi]        = price_bcd[4*gi +: 4];
    assign w_credit_bcd[4*gi +: 4] = r_cred[gi];
    // All-nines minus the coin, digit-wise; no borrows since every coin digit is <= 9
    assign w_limit[4*gi +: 4]      = 4'd9 - w_coin_dig[gi];
  end

  // Packed BCD orders the same as the numbers it encodes, so plain compares suffice
  assign w_coin_wide = (DIGITS < 2) && (w_coin_bcd[7:4] != 4'd0);
  assign w_overflow  = w_coin_wide || (w_credit_bcd > w_limit);
  assign w_short     = w_credit_bcd < price_bcd;

  // Digit arithmetic for the digit currently strobed, using the held operand/cin/mode
  logic [3:0]    w_cur_cred, w_cur_num, w_add_dig, w_sub_dig, w_new_dig;
  logic [4:0]    w_sum, w_take;
  logic          w_carry, w_borrow, w_cout;
  logic [DW-1:0] w_dig_inc;

  assign w_cur_cred = r_cred[r_dig];
  assign w_cur_num  = r_oper[r_dig];
  assign w_sum      = {1'b0, w_cur_cred} + {1'b0, w_cur_num} + {4'd0, r_dig_cin};
  assign w_carry    = w_sum > 5'd9;
  assign w_add_dig  = w_carry ? 4'(w_sum - 5'd10) : w_sum[3:0];
  assign w_take     = {1'b0, w_cur_num} + {4'd0, r_dig_cin};
  assign w_borrow   = {1'b0, w_cur_cred} < w_take;
  assign w_sub_dig  = w_borrow ? 4'({1'b0, w_cur_cred} + 5'd10 - w_take)
                               : 4'({1'b0, w_cur_cred} - w_take);
  assign w_new_dig  = r_dig_mode ? w_sub_dig : w_add_dig;
  assign w_cout     = r_dig_mode ? w_borrow : w_carry;
  assign w_dig_inc  = r_dig + 1'b1;

  // Next-state and next-output logic; outputs are registered from these values
  always_comb begin
    w_state_next       = r_state;
    w_dig_next         = r_dig;
    w_coin_code_next   = r_coin_code;
    w_pend_valid_next  = r_pend_valid;
    w_pend_code_next   = r_pend_code;
    w_oper_next        = r_oper;
    w_cred_next        = r_cred;
    w_dig_num_next     = r_dig_num;
    w_dig_cin_next     = r_dig_cin;
    w_dig_mode_next    = r_dig_mode;
    w_dig_en_next      = '0;
    w_buy_ack_next     = 1'b0;
    w_buy_reject_next  = 1'b0;
    w_coin_reject_next = 1'b0;
    w_done_next        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (r_pend_valid) begin
          // Pending coin goes first; a coin arriving now refills the slot
          w_coin_code_next  = r_pend_code;
          w_pend_valid_next = coin_valid;
          w_pend_code_next  = coin_code;
          w_state_next      = S_LOAD;
        end else if (coin_valid) begin
          w_coin_code_next = coin_code;
          w_state_next     = S_LOAD;
        end else if (buy_req) begin
          w_buy_ack_next    = 1'b1;
          w_buy_reject_next = w_short;
          w_state_next      = S_CHECK;
        end
      end
      S_LOAD: begin
        if (w_overflow) begin
          w_coin_reject_next = 1'b1;
          w_state_next       = S_IDLE;
        end else begin
          for (int i = 0; i < DIGITS; i++) w_oper_next[i] = w_coin_dig[i];
          w_dig_next      = '0;
          w_dig_num_next  = w_coin_dig[0];
          w_dig_cin_next  = 1'b0;
          w_dig_mode_next = 1'b0;
          w_state_next    = S_SETUP;
        end
      end
      S_CHECK: begin
        if (r_buy_reject) begin
          w_state_next = S_IDLE;
        end else begin
          for (int i = 0; i < DIGITS; i++) w_oper_next[i] = w_price_dig[i];
          w_dig_next      = '0;
          w_dig_num_next  = w_price_dig[0];
          w_dig_cin_next  = 1'b0;
          w_dig_mode_next = 1'b1;
          w_state_next    = S_SETUP;
        end
      end
      S_SETUP: begin
        w_dig_en_next = DIGITS'(1) << r_dig;
        w_state_next  = S_STROBE;
      end
      S_STROBE: begin
        w_cred_next[r_dig] = w_new_dig;
        if (r_dig == LAST_DIG) begin
          w_done_next  = 1'b1;
          w_state_next = S_DONE;
        end else begin
          w_dig_next     = w_dig_inc;
          w_dig_num_next = r_oper[w_dig_inc];
          w_dig_cin_next = w_cout;
          w_state_next   = S_SETUP;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase

    // Coins arriving mid-operation: one may wait, any further one is dropped
    if (r_state != S_IDLE && coin_valid) begin
      if (r_pend_valid) begin
        w_coin_reject_next = 1'b1;
      end else begin
        w_pend_valid_next = 1'b1;
        w_pend_code_next  = coin_code;
      end
    end
  end

  // State and output registers; clear wipes everything immediately
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state       <= S_IDLE;
      r_dig         <= '0;
      r_coin_code   <= 2'b00;
      r_pend_valid  <= 1'b0;
      r_pend_code   <= 2'b00;
      for (int i = 0; i < DIGITS; i++) begin
        r_oper[i] <= 4'd0;
        r_cred[i] <= 4'd0;
      end
      r_buy_ack     <= 1'b0;
      r_buy_reject  <= 1'b0;
      r_coin_reject <= 1'b0;
      r_dig_num     <= 4'd0;
      r_dig_cin     <= 1'b0;
      r_dig_mode    <= 1'b0;
      r_dig_en      <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_dig         <= w_dig_next;
      r_coin_code   <= w_coin_code_next;
      r_pend_valid  <= w_pend_valid_next;
      r_pend_code   <= w_pend_code_next;
      r_oper        <= w_oper_next;
      r_cred        <= w_cred_next;
      r_buy_ack     <= w_buy_ack_next;
      r_buy_reject  <= w_buy_reject_next;
      r_coin_reject <= w_coin_reject_next;
      r_dig_num     <= w_dig_num_next;
      r_dig_cin     <= w_dig_cin_next;
      r_dig_mode    <= w_dig_mode_next;
      r_dig_en      <= w_dig_en_next;
      r_busy        <= (w_state_next != S_IDLE);
      r_done        <= w_done_next;
    end
  end

  assign buy_ack     = r_buy_ack;
  assign buy_reject  = r_buy_reject;
  assign coin_reject = r_coin_reject;
  assign dig_num     = r_dig_num;
  assign dig_cin     = r_dig_cin;
  assign dig_mode    = r_dig_mode;
  assign dig_en      = r_dig_en;
  assign credit_bcd  = w_credit_bcd;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_money_sequencer.sv
// Testbench for money_sequencer (DIGITS=3): scenario tasks push expected strobes/events,
// a negedge monitor records what the DUT produces, and each task compares the two.
module tb_money_sequencer;
  localparam int DIGITS = 3;

  logic        clk = 1'b0;
  logic        clear = 1'b1;
  logic        coin_valid = 1'b0;
  logic [1:0]  coin_code = 2'b00;
  logic        buy_req = 1'b0;
  logic [11:0] price_bcd = 12'h000;
  logic        buy_ack, buy_reject, coin_reject;
  logic [3:0]  dig_num;
  logic        dig_cin, dig_mode;
  logic [2:0]  dig_en;
  logic [11:0] credit_bcd;
  logic        busy, done;

  money_sequencer #(.DIGITS(DIGITS)) dut (
    .clk(clk), .clear(clear), .coin_valid(coin_valid), .coin_code(coin_code),
    .buy_req(buy_req), .price_bcd(price_bcd), .buy_ack(buy_ack), .buy_reject(buy_reject),
    .coin_reject(coin_reject), .dig_num(dig_num), .dig_cin(dig_cin), .dig_mode(dig_mode),
    .dig_en(dig_en), .credit_bcd(credit_bcd), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;
  int g_base = 0;

  // Strobe record: {rel cycle[8], dig_en[3], dig_num[4], cin, mode, operands-stable}
  logic [17:0] obs_q[$];
  logic [17:0] exp_q[$];
  int          done_q[$];
  int          crej_q[$];
  logic [8:0]  ack_q[$];
  logic [3:0]  prev_num = 4'd0;
  logic        prev_cin = 1'b0;
  logic        prev_mode = 1'b0;

  // Monitor: samples on the falling edge, relative to the cycle of the last stimulus
  always @(negedge clk) begin
    logic [7:0] rel;
    logic       stable;
    rel = 8'(cyc - g_base);
    stable = (dig_num == prev_num) && (dig_cin == prev_cin) && (dig_mode == prev_mode);
    if (dig_en != 3'b000) obs_q.push_back({rel, dig_en, dig_num, dig_cin, dig_mode, stable});
    if (done) done_q.push_back(int'(rel));
    if (coin_reject) crej_q.push_back(int'(rel));
    if (buy_ack) begin
      ack_q.push_back({rel, buy_reject});
      buy_req = 1'b0;
    end
    prev_num = dig_num;
    prev_cin = dig_cin;
    prev_mode = dig_mode;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [17:0] stb(int rel, int d, int num, logic cin, logic mode);
    return {8'(rel), 3'(1 << d), 4'(num), cin, mode, 1'b1};
  endfunction

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_op();
    g_base = cyc;
    obs_q.delete(); exp_q.delete(); done_q.delete(); crej_q.delete(); ack_q.delete();
  endtask

  task automatic pulse_coin(logic [1:0] code);
    coin_valid = 1'b1;
    coin_code = code;
    @(negedge clk);
    coin_valid = 1'b0;
  endtask

  task automatic add_coin(logic [1:0] code);
    start_op();
    pulse_coin(code);
    step(8);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks += 10;
    if (dig_en !== 3'b000) $display("FAIL reset_dig_en: got %b want 000", dig_en); else n_pass++;
    if (dig_num !== 4'd0) $display("FAIL reset_dig_num: got %h want 0", dig_num); else n_pass++;
    if (dig_cin !== 1'b0) $display("FAIL reset_dig_cin: got %b want 0", dig_cin); else n_pass++;
    if (dig_mode !== 1'b0) $display("FAIL reset_dig_mode: got %b want 0", dig_mode); else n_pass++;
    if (credit_bcd !== 12'h000) $display("FAIL reset_credit: got %h want 000", credit_bcd); else n_pass++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    if (buy_ack !== 1'b0) $display("FAIL reset_buy_ack: got %b want 0", buy_ack); else n_pass++;
    if (buy_reject !== 1'b0) $display("FAIL reset_buy_reject: got %b want 0", buy_reject); else n_pass++;
    if (coin_reject !== 1'b0) $display("FAIL reset_coin_reject: got %b want 0", coin_reject); else n_pass++;
    $display("reset: outputs sampled with clear high");
    clear = 1'b0;
    step(1);
  endtask

  // Coin 10 then coin 5 from zero credit
  task automatic test_coin_add();
    int          nums[2][3] = '{'{0, 1, 0}, '{5, 0, 0}};
    logic [1:0]  codes[2] = '{2'b11, 2'b10};
    logic [11:0] cred_exp[2] = '{12'h010, 12'h015};
    do_clear();
    for (int k = 0; k < 2; k++) begin
      start_op();
      for (int d = 0; d < 3; d++) exp_q.push_back(stb(3 + 2*d, d, nums[k][d], 1'b0, 1'b0));
      pulse_coin(codes[k]);
      step(8);
      while (exp_q.size() > 0) begin
        logic [17:0] e, o;
        e = exp_q.pop_front();
        n_checks++;
        if (obs_q.size() == 0) $display("FAIL coin_add_strobe: got none want %h", e);
        else begin
          o = obs_q.pop_front();
          if (o !== e) $display("FAIL coin_add_strobe: got %h want %h", o, e); else n_pass++;
        end
      end
      n_checks += 2;
      if (obs_q.size() != 0) $display("FAIL coin_add_extra: got %0d extra strobes want 0", obs_q.size()); else n_pass++;
      if (done_q.size() != 1 || done_q[0] != 8) $display("FAIL coin_add_done: got n=%0d want one at c8", done_q.size()); else n_pass++;
      n_checks++;
      if (credit_bcd !== cred_exp[k]) $display("FAIL coin_add_credit: got %h want %h", credit_bcd, cred_exp[k]); else n_pass++;
      $display("coin code=%b: credit=%h", codes[k], credit_bcd);
    end
  endtask

  // Credit 005 plus coin 5 carries into digit 1
  task automatic test_carry();
    do_clear();
    add_coin(2'b10);
    start_op();
    exp_q.push_back(stb(3, 0, 5, 1'b0, 1'b0));
    exp_q.push_back(stb(5, 1, 0, 1'b1, 1'b0));
    exp_q.push_back(stb(7, 2, 0, 1'b0, 1'b0));
    pulse_coin(2'b10);
    step(8);
    while (exp_q.size() > 0) begin
      logic [17:0] e, o;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) $display("FAIL carry_strobe: got none want %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL carry_strobe: got %h want %h", o, e); else n_pass++;
      end
    end
    n_checks += 2;
    if (done_q.size() != 1 || done_q[0] != 8) $display("FAIL carry_done: got n=%0d want one at c8", done_q.size()); else n_pass++;
    if (credit_bcd !== 12'h010) $display("FAIL carry_credit: got %h want 010", credit_bcd); else n_pass++;
    $display("carry: 005 + 5 -> credit=%h", credit_bcd);
  endtask

  // Credit 020, buy 015: borrow out of digit 0
  task automatic test_buy();
    do_clear();
    add_coin(2'b11);
    add_coin(2'b11);
    start_op();
    exp_q.push_back(stb(3, 0, 5, 1'b0, 1'b1));
    exp_q.push_back(stb(5, 1, 1, 1'b1, 1'b1));
    exp_q.push_back(stb(7, 2, 0, 1'b0, 1'b1));
    price_bcd = 12'h015;
    buy_req = 1'b1;
    step(9);
    while (exp_q.size() > 0) begin
      logic [17:0] e, o;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) $display("FAIL buy_strobe: got none want %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL buy_strobe: got %h want %h", o, e); else n_pass++;
      end
    end
    n_checks += 3;
    if (ack_q.size() != 1 || ack_q[0] !== {8'd1, 1'b0}) $display("FAIL buy_ack: got n=%0d want ack c1 reject 0", ack_q.size()); else n_pass++;
    if (done_q.size() != 1 || done_q[0] != 8) $display("FAIL buy_done: got n=%0d want one at c8", done_q.size()); else n_pass++;
    if (credit_bcd !== 12'h005) $display("FAIL buy_credit: got %h want 005", credit_bcd); else n_pass++;
    $display("buy 015 from 020: credit=%h", credit_bcd);
  endtask

  // Credit 005, buy 010: refused, nothing strobed
  task automatic test_buy_reject();
    do_clear();
    add_coin(2'b10);
    start_op();
    price_bcd = 12'h010;
    buy_req = 1'b1;
    step(10);
    n_checks += 5;
    if (ack_q.size() != 1 || ack_q[0] !== {8'd1, 1'b1}) $display("FAIL reject_ack: got n=%0d want ack+reject c1", ack_q.size()); else n_pass++;
    if (obs_q.size() != 0) $display("FAIL reject_strobes: got %0d want 0", obs_q.size()); else n_pass++;
    if (done_q.size() != 0) $display("FAIL reject_done: got %0d want 0", done_q.size()); else n_pass++;
    if (credit_bcd !== 12'h005) $display("FAIL reject_credit: got %h want 005", credit_bcd); else n_pass++;
    if (buy_req !== 1'b0) $display("FAIL reject_req_drop: got %b want 0", buy_req); else n_pass++;
    $display("buy 010 from 005: refused, credit=%h", credit_bcd);
  endtask

  // Near the top of the credit range
  task automatic test_overflow();
    logic [1:0]  codes[4] = '{2'b10, 2'b01, 2'b01, 2'b00};
    logic        rej[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [11:0] cred_exp[4] = '{12'h995, 12'h997, 12'h999, 12'h999};
    do_clear();
    repeat (99) add_coin(2'b11);
    add_coin(2'b10);
    n_checks++;
    if (credit_bcd !== 12'h995) $display("FAIL fill_credit: got %h want 995", credit_bcd); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      start_op();
      pulse_coin(codes[k]);
      step(8);
      n_checks += 3;
      if (rej[k]) begin
        if (crej_q.size() != 1 || crej_q[0] != 2) $display("FAIL ovf_reject: got n=%0d want one at c2", crej_q.size()); else n_pass++;
        if (obs_q.size() != 0) $display("FAIL ovf_strobes: got %0d want 0", obs_q.size()); else n_pass++;
      end else begin
        if (crej_q.size() != 0) $display("FAIL ovf_reject: got %0d want 0", crej_q.size()); else n_pass++;
        if (obs_q.size() != 3) $display("FAIL ovf_strobes: got %0d want 3", obs_q.size()); else n_pass++;
      end
      if (credit_bcd !== cred_exp[k]) $display("FAIL ovf_credit: got %h want %h", credit_bcd, cred_exp[k]); else n_pass++;
      $display("coin code=%b near full: reject=%b credit=%h", codes[k], rej[k], credit_bcd);
    end
  endtask

  // Three coins during one operation: second waits, third is dropped
  task automatic test_pending();
    do_clear();
    start_op();
    exp_q.push_back(stb(3, 0, 1, 1'b0, 1'b0));
    exp_q.push_back(stb(5, 1, 0, 1'b0, 1'b0));
    exp_q.push_back(stb(7, 2, 0, 1'b0, 1'b0));
    exp_q.push_back(stb(12, 0, 2, 1'b0, 1'b0));
    exp_q.push_back(stb(14, 1, 0, 1'b0, 1'b0));
    exp_q.push_back(stb(16, 2, 0, 1'b0, 1'b0));
    pulse_coin(2'b00);
    step(1);
    pulse_coin(2'b01);
    step(1);
    pulse_coin(2'b10);
    step(14);
    while (exp_q.size() > 0) begin
      logic [17:0] e, o;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) $display("FAIL pend_strobe: got none want %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL pend_strobe: got %h want %h", o, e); else n_pass++;
      end
    end
    n_checks += 3;
    if (crej_q.size() != 1 || crej_q[0] != 5) $display("FAIL pend_reject: got n=%0d want one at c5", crej_q.size()); else n_pass++;
    if (done_q.size() != 2 || done_q[0] != 8 || done_q[1] != 17) $display("FAIL pend_done: got n=%0d want c8,c17", done_q.size()); else n_pass++;
    if (credit_bcd !== 12'h003) $display("FAIL pend_credit: got %h want 003", credit_bcd); else n_pass++;
    $display("pending: 1 + 2 accepted, third coin dropped, credit=%h", credit_bcd);
  endtask

  // clear in the middle of an add
  task automatic test_clear_mid();
    do_clear();
    add_coin(2'b10);
    start_op();
    pulse_coin(2'b11);
    step(2);
    n_checks++;
    if (dig_en !== 3'b001) $display("FAIL mid_first_strobe: got %b want 001", dig_en); else n_pass++;
    step(1);
    clear = 1'b1;
    #1;
    n_checks += 5;
    if (dig_en !== 3'b000) $display("FAIL mid_dig_en: got %b want 000", dig_en); else n_pass++;
    if (dig_num !== 4'd0) $display("FAIL mid_dig_num: got %h want 0", dig_num); else n_pass++;
    if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else n_pass++;
    if (credit_bcd !== 12'h000) $display("FAIL mid_credit: got %h want 000", credit_bcd); else n_pass++;
    if (done !== 1'b0) $display("FAIL mid_done: got %b want 0", done); else n_pass++;
    @(negedge clk);
    clear = 1'b0;
    step(1);
    add_coin(2'b00);
    n_checks++;
    if (credit_bcd !== 12'h001) $display("FAIL mid_after_credit: got %h want 001", credit_bcd); else n_pass++;
    $display("clear mid-add: credit=%h after next coin", credit_bcd);
  endtask

  // Coin and buy in the same idle cycle: coin first, then the purchase
  task automatic test_back_to_back();
    do_clear();
    add_coin(2'b11);
    start_op();
    exp_q.push_back(stb(3, 0, 5, 1'b0, 1'b0));
    exp_q.push_back(stb(5, 1, 0, 1'b0, 1'b0));
    exp_q.push_back(stb(7, 2, 0, 1'b0, 1'b0));
    exp_q.push_back(stb(12, 0, 2, 1'b0, 1'b1));
    exp_q.push_back(stb(14, 1, 1, 1'b0, 1'b1));
    exp_q.push_back(stb(16, 2, 0, 1'b0, 1'b1));
    price_bcd = 12'h012;
    buy_req = 1'b1;
    pulse_coin(2'b10);
    step(18);
    while (exp_q.size() > 0) begin
      logic [17:0] e, o;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) $display("FAIL b2b_strobe: got none want %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL b2b_strobe: got %h want %h", o, e); else n_pass++;
      end
    end
    n_checks += 3;
    if (ack_q.size() != 1 || ack_q[0] !== {8'd10, 1'b0}) $display("FAIL b2b_ack: got n=%0d want ack c10 reject 0", ack_q.size()); else n_pass++;
    if (done_q.size() != 2 || done_q[0] != 8 || done_q[1] != 17) $display("FAIL b2b_done: got n=%0d want c8,c17", done_q.size()); else n_pass++;
    if (credit_bcd !== 12'h003) $display("FAIL b2b_credit: got %h want 003", credit_bcd); else n_pass++;
    $display("coin 5 + buy 012 together: credit=%h", credit_bcd);
  endtask

  initial begin
    test_reset();
    test_coin_add();
    test_carry();
    test_buy();
    test_buy_reject();
    test_overflow();
    test_pending();
    test_clear_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
